branch_pht_scheduler: RTL and testbench

- Owns a single-ported pattern history table (PHT) of 2-bit saturating counters.
- Schedules the one port per cycle between decode-stage prediction lookups and execute-stage feedback updates.
- Feedback is buffered in a small FIFO and drained when decode leaves the port idle. When the FIFO fills, decode is stalled and the FIFO is force-drained.
- Sits inside branch_controller in place of the stateless predictors. o_req_ready feeds the hazard controller's decode stall.

---
 rtl/branch_pht_scheduler_pkg.sv | 37 +++
 rtl/branch_pht_scheduler_if.sv | 33 +++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/branch_pht_scheduler.sv | 136 +++++++++++++
 tb/tb_branch_pht_scheduler.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/branch_pht_scheduler_pkg.sv
// Shared types for the PHT scheduler: branch outcome, queued update record,
// scheduler state and the 2-bit saturating counter step.
package branch_pht_scheduler_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    localparam int unsigned PHT_MAX_INDEX_BITS = 16;

    typedef struct packed {
        logic [PHT_MAX_INDEX_BITS-1:0] index;
        BranchOutcome                  outcome;
    } pht_update_t;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        FORCE
    } pht_sched_state_e;

    function automatic logic [1:0] pht_sat_update(
        input logic [1:0]   cur,
        input BranchOutcome outcome
    );
        logic [1:0] nxt;
        nxt = cur;
        if (outcome == TAKEN) begin
            if (cur != 2'b11) nxt = cur + 2'd1;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_pht_scheduler_if.sv
// Decode lookup and execute feedback handshakes of the PHT scheduler.
// master = decode/execute side, slave = scheduler.
interface branch_pht_scheduler_if #(
    parameter int ADDR_WIDTH = 32
);
    import branch_pht_scheduler_pkg::*;

    logic                  i_req_valid;
    logic [ADDR_WIDTH-1:0] i_req_pc;
    logic                  o_req_ready;
    BranchOutcome          o_req_prediction;

    logic                  i_fb_valid;
    logic [ADDR_WIDTH-1:0] i_fb_pc;
    BranchOutcome          i_fb_prediction;
    BranchOutcome          i_fb_outcome;
    logic                  o_fb_ready;

    modport master (
        output i_req_valid, i_req_pc,
        input  o_req_ready, o_req_prediction,
        output i_fb_valid, i_fb_pc, i_fb_prediction, i_fb_outcome,
        input  o_fb_ready
    );

    modport slave (
        input  i_req_valid, i_req_pc,
        output o_req_ready, o_req_prediction,
        input  i_fb_valid, i_fb_pc, i_fb_prediction, i_fb_outcome,
        output o_fb_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with occupancy count; push while full is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_q];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        if (do_push && !do_pop) count_d = count_q + CW'(1);
        if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/branch_pht_scheduler.sv
// Single-ported 2-bit PHT shared between decode lookups and queued execute
// feedback; the queue drains on idle cycles and forces a stall when full.
module branch_pht_scheduler
    import branch_pht_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_pht_scheduler_if.slave bus,
    output logic [CNT_WIDTH-1:0] o_force_drain_cnt,
    output logic [CNT_WIDTH-1:0] o_mispredict_cnt
);

    localparam int PHT_ENTRIES = 1 << INDEX_BITS;
    localparam int CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int UW          = $bits(pht_update_t);

    logic [1:0] pht_q [PHT_ENTRIES];
    logic [1:0] pht_d [PHT_ENTRIES];

    pht_sched_state_e     state_q, state_d;
    logic [CNT_WIDTH-1:0] force_cnt_q, force_cnt_d;
    logic [CNT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;

    logic [INDEX_BITS-1:0] req_idx, fb_idx, head_idx;
    logic                  force_mode, push, pop;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count, next_count;
    pht_update_t           push_upd, head;
    logic [UW-1:0]         pop_data;

    assign req_idx    = bus.i_req_pc[INDEX_BITS+1:2];
    assign fb_idx     = bus.i_fb_pc[INDEX_BITS+1:2];
    assign force_mode = (state_q == FORCE);

    // FORCE owns the port; otherwise a lookup beats a pending drain.
    assign pop  = !fifo_empty && (force_mode || !bus.i_req_valid);
    assign push = bus.i_fb_valid && bus.o_fb_ready;

    assign bus.o_req_ready      = !force_mode;
    assign bus.o_fb_ready       = !fifo_full || pop;
    assign bus.o_req_prediction =
        (bus.i_req_valid && !force_mode && pht_q[req_idx][1])
            ? TAKEN : NOT_TAKEN;

    always_comb begin
        push_upd                        = '0;
        push_upd.index[INDEX_BITS-1:0]  = fb_idx;
        push_upd.outcome                = bus.i_fb_outcome;
    end

    assign head     = pop_data;
    assign head_idx = head.index[INDEX_BITS-1:0];

    sync_fifo #(
        .WIDTH (UW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_upd),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        pht_d = pht_q;
        if (pop) pht_d[head_idx] = pht_sat_update(pht_q[head_idx], head.outcome);
    end

    always_comb begin
        next_count = fifo_count;
        if (push && !pop) next_count = fifo_count + CW'(1);
        if (pop && !push) next_count = fifo_count - CW'(1);
    end

    always_comb begin
        state_d     = state_q;
        force_cnt_d = force_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (next_count != '0) state_d = PENDING;
            end
            PENDING: begin
                if (next_count == CW'(FIFO_DEPTH)) begin
                    state_d = FORCE;
                    if (force_cnt_q != '1) force_cnt_d = force_cnt_q + CNT_WIDTH'(1);
                end else if (next_count == '0) begin
                    state_d = IDLE;
                end
            end
            FORCE: begin
                if (next_count == '0) state_d = IDLE;
                else if (next_count <= CW'(FIFO_DEPTH / 2)) state_d = PENDING;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mis_cnt_d = mis_cnt_q;
        if (push && (bus.i_fb_prediction != bus.i_fb_outcome) && (mis_cnt_q != '1))
            mis_cnt_d = mis_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= 2'b10;
            state_q     <= IDLE;
            force_cnt_q <= '0;
            mis_cnt_q   <= '0;
        end else begin
            pht_q       <= pht_d;
            state_q     <= state_d;
            force_cnt_q <= force_cnt_d;
            mis_cnt_q   <= mis_cnt_d;
        end
    end

    assign o_force_drain_cnt = force_cnt_q;
    assign o_mispredict_cnt  = mis_cnt_q;

    logic unused_bits;
    assign unused_bits = ^{bus.i_req_pc[ADDR_WIDTH-1:INDEX_BITS+2], bus.i_req_pc[1:0],
                           bus.i_fb_pc[ADDR_WIDTH-1:INDEX_BITS+2], bus.i_fb_pc[1:0],
                           head.index[PHT_MAX_INDEX_BITS-1:INDEX_BITS]};

endmodule

// File: tb/tb_branch_pht_scheduler.sv
// Directed bench for branch_pht_scheduler: reset, drain, force drain,
// saturation, aliasing and reset during a forced drain.
module tb_branch_pht_scheduler;
    import branch_pht_scheduler_pkg::*;

    logic clk;
    logic rst_n;
    logic [15:0] force_cnt, mis_cnt;
    int checks = 0;
    int errors = 0;

    branch_pht_scheduler_if #(.ADDR_WIDTH(32)) bus ();

    branch_pht_scheduler #(
        .ADDR_WIDTH (32),
        .INDEX_BITS (6),
        .FIFO_DEPTH (4),
        .CNT_WIDTH  (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus),
        .o_force_drain_cnt (force_cnt),
        .o_mispredict_cnt  (mis_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fb(input logic [31:0] pc, input BranchOutcome pred, input BranchOutcome out);
        bus.i_fb_valid      = 1'b1;
        bus.i_fb_pc         = pc;
        bus.i_fb_prediction = pred;
        bus.i_fb_outcome    = out;
    endtask

    task automatic req(input logic v, input logic [31:0] pc);
        bus.i_req_valid = v;
        bus.i_req_pc    = pc;
    endtask

    initial begin
        rst_n = 1'b0;
        req(1'b0, 32'h0);
        bus.i_fb_valid      = 1'b0;
        bus.i_fb_pc         = 32'h0;
        bus.i_fb_prediction = NOT_TAKEN;
        bus.i_fb_outcome    = NOT_TAKEN;
        #1;
        check("rst_req_ready", 32'(bus.o_req_ready), 32'd1);
        check("rst_fb_ready", 32'(bus.o_fb_ready), 32'd1);
        check("rst_pred", 32'(bus.o_req_prediction), 32'(NOT_TAKEN));
        check("rst_force_cnt", 32'(force_cnt), 32'd0);
        check("rst_mis_cnt", 32'(mis_cnt), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // weakly-taken after reset
        req(1'b1, 32'h100);
        #1;
        check("lk100_pred", 32'(bus.o_req_prediction), 32'(TAKEN));
        check("lk100_ready", 32'(bus.o_req_ready), 32'd1);

        // single NOT_TAKEN feedback on 0x40, drained on an idle cycle
        req(1'b0, 32'h0);
        fb(32'h40, TAKEN, NOT_TAKEN);
        #1;
        check("fb40_ready", 32'(bus.o_fb_ready), 32'd1);
        tick();
        bus.i_fb_valid = 1'b0;
        req(1'b1, 32'h40);
        #1;
        check("fb40_no_bypass_cnt", 32'(dut.u_fifo.count), 32'd1);
        check("fb40_stale_pred", 32'(bus.o_req_prediction), 32'(TAKEN));
        tick();
        check("fb40_lookup_wins_cnt", 32'(dut.u_fifo.count), 32'd1);
        req(1'b0, 32'h0);
        tick();
        check("fb40_drained_cnt", 32'(dut.u_fifo.count), 32'd0);
        req(1'b1, 32'h40);
        #1;
        check("fb40_pred_nt", 32'(bus.o_req_prediction), 32'(NOT_TAKEN));
        check("fb40_entry", 32'(dut.pht_q[16]), 32'd1);
        check("fb40_mis_cnt", 32'(mis_cnt), 32'd1);

        // lookups every cycle while four feedbacks fill the FIFO
        req(1'b1, 32'h200);
        fb(32'h80, TAKEN, TAKEN);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fill_req_ready", 32'(bus.o_req_ready), 32'd1);
            check("fill_fb_ready", 32'(bus.o_fb_ready), 32'd1);
            tick();
        end
        bus.i_fb_valid = 1'b0;
        #1;
        check("force_state", 32'(dut.state_q), 32'(FORCE));
        check("force_cnt4", 32'(dut.u_fifo.count), 32'd4);
        check("force_ready0_a", 32'(bus.o_req_ready), 32'd0);
        check("force_pred_nt", 32'(bus.o_req_prediction), 32'(NOT_TAKEN));
        check("force_drain_cnt1", 32'(force_cnt), 32'd1);
        tick();
        check("force_cnt3", 32'(dut.u_fifo.count), 32'd3);
        check("force_ready0_b", 32'(bus.o_req_ready), 32'd0);
        tick();
        check("force_cnt2", 32'(dut.u_fifo.count), 32'd2);
        check("force_to_pending", 32'(dut.state_q), 32'(PENDING));
        check("force_ready1", 32'(bus.o_req_ready), 32'd1);
        check("force_pred_after", 32'(bus.o_req_prediction), 32'(TAKEN));
        check("force_mis_unchanged", 32'(mis_cnt), 32'd1);
        req(1'b0, 32'h0);
        tick();
        tick();
        check("force_empty", 32'(dut.u_fifo.count), 32'd0);
        check("force_idle", 32'(dut.state_q), 32'(IDLE));

        // saturation at 2'b11 then one decrement
        for (int i = 0; i < 5; i++) begin
            fb(32'h80, TAKEN, TAKEN);
            tick();
        end
        bus.i_fb_valid = 1'b0;
        tick();
        check("sat_entry_11", 32'(dut.pht_q[32]), 32'd3);
        fb(32'h80, TAKEN, NOT_TAKEN);
        tick();
        bus.i_fb_valid = 1'b0;
        tick();
        check("sat_entry_10", 32'(dut.pht_q[32]), 32'd2);
        check("sat_mis_cnt", 32'(mis_cnt), 32'd2);
        req(1'b1, 32'h80);
        #1;
        check("sat_pred_taken", 32'(bus.o_req_prediction), 32'(TAKEN));

        // aliasing: 0x40 and 0x140 share index 0x10
        req(1'b0, 32'h0);
        fb(32'h40, TAKEN, NOT_TAKEN);
        tick();
        fb(32'h40, TAKEN, NOT_TAKEN);
        tick();
        bus.i_fb_valid = 1'b0;
        tick();
        check("alias_empty", 32'(dut.u_fifo.count), 32'd0);
        check("alias_mis_cnt", 32'(mis_cnt), 32'd4);
        check("alias_entry", 32'(dut.pht_q[16]), 32'd0);
        req(1'b1, 32'h140);
        #1;
        check("alias_pred", 32'(bus.o_req_prediction), 32'(NOT_TAKEN));

        // reset in the middle of a forced drain
        req(1'b1, 32'h200);
        fb(32'h80, TAKEN, TAKEN);
        for (int i = 0; i < 4; i++) tick();
        bus.i_fb_valid = 1'b0;
        tick();
        check("mid_force_state", 32'(dut.state_q), 32'(FORCE));
        check("mid_force_cnt3", 32'(dut.u_fifo.count), 32'd3);
        check("mid_force_entry", 32'(dut.pht_q[32]), 32'd3);
        check("mid_force_drains", 32'(force_cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", 32'(bus.o_req_ready), 32'd1);
        check("arst_fifo_empty", 32'(dut.u_fifo.count), 32'd0);
        check("arst_state", 32'(dut.state_q), 32'(IDLE));
        check("arst_entry32", 32'(dut.pht_q[32]), 32'd2);
        check("arst_entry16", 32'(dut.pht_q[16]), 32'd2);
        check("arst_force_cnt", 32'(force_cnt), 32'd0);
        check("arst_mis_cnt", 32'(mis_cnt), 32'd0);
        check("arst_pred", 32'(bus.o_req_prediction), 32'(TAKEN));
        tick();
        rst_n = 1'b1;
        req(1'b1, 32'h40);
        #1;
        check("post_rst_pred", 32'(bus.o_req_prediction), 32'(TAKEN));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
